sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_responder_if.sv | 20 ++
 rtl/sdram_responder.sv | 176 +++++++++++++++++
 tb/tb_sdram_responder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_responder_if.sv
// Command, address and byte-mask pins between an SDRAM controller and the responder.
interface sdram_responder_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int BANK_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [BANK_WIDTH-1:0] bank_addr;
  logic                  clock_enable;
  logic                  cs_n;
  logic                  ras_n;
  logic                  cas_n;
  logic                  we_n;
  logic                  data_mask_low;
  logic                  data_mask_high;

  modport master (output addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
                  data_mask_low, data_mask_high);
  modport slave  (input  addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
                  data_mask_low, data_mask_high);
endinterface

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device: init sequencing, bank tracking, CAS-latency read pipe, protocol checks.
//   state     | meaning
//   ST_PWR    | power-up, waiting for PRE with A10=1
//   ST_REF1   | waiting for first REF
//   ST_REF2   | waiting for second REF
//   ST_MRS    | waiting for mode register set
//   ST_READY  | initialised, normal operation
module sdram_responder #(
  parameter int ROW_WIDTH  = 9,
  parameter int COL_WIDTH  = 9,
  parameter int BANK_WIDTH = 2,
  parameter int MEM_AW     = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  sdram_responder_if.slave   bus,
  inout  wire  [15:0]        data,
  output logic               init_done,
  output logic               cmd_error,
  output logic [2:0]         err_code,
  output logic [15:0]        refresh_count
);
  localparam int AW = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH;
  localparam int NB = 1 << BANK_WIDTH;

  localparam logic [2:0] ST_PWR   = 3'd0;
  localparam logic [2:0] ST_REF1  = 3'd1;
  localparam logic [2:0] ST_REF2  = 3'd2;
  localparam logic [2:0] ST_MRS   = 3'd3;
  localparam logic [2:0] ST_READY = 3'd4;

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  logic [2:0]           state;
  logic [NB-1:0]        bank_open;
  logic [ROW_WIDTH-1:0] bank_row [NB];
  logic [1:0]           cl;
  logic [15:0]          mem [1 << MEM_AW];
  logic [2:0]           rd_vld;
  logic [2:0][15:0]     rd_dat;
  logic [2:0]           err_now;
  logic                 a10;
  logic                 data_oe;

  wire                  accept    = bus.clock_enable & ~bus.cs_n;
  wire [2:0]            cmd       = {bus.ras_n, bus.cas_n, bus.we_n};
  wire                  sel_open  = bank_open[bus.bank_addr];
  wire                  any_open  = |bank_open;
  wire                  ready     = (state == ST_READY);
  wire                  mode_ok   = (bus.addr[6:4] == 3'd2 || bus.addr[6:4] == 3'd3) &&
                                    (bus.addr[2:0] == 3'd0);
  wire                  is_wr     = accept && (cmd == C_WR);
  wire                  rd_ok     = accept && (cmd == C_RD) && ready && sel_open;
  wire                  wr_ok     = is_wr && ready && sel_open;
  wire                  act_ok    = accept && (cmd == C_ACT) && ready && !sel_open;
  wire [MEM_AW-1:0]     mem_idx   = MEM_AW'({bus.bank_addr, bank_row[bus.bank_addr],
                                             bus.addr[COL_WIDTH-1:0]});

  generate
    if (AW > 10) begin : g_a10
      assign a10 = bus.addr[10];
    end else begin : g_no_a10
      assign a10 = 1'b0;
    end
  endgenerate

  // An incoming WRITE owns the bus for its data cycle, so a read due in that cycle is dropped.
  assign data_oe = rd_vld[0] & ~is_wr;
  assign data    = data_oe ? rd_dat[0] : 16'hzzzz;

  always_comb begin
    err_now = 3'd0;
    if (accept && cmd != C_NOP && cmd != C_BST) begin
      if (!ready) begin
        case (state)
          ST_PWR:          if (!(cmd == C_PRE && a10)) err_now = 3'd1;
          ST_REF1, ST_REF2: if (cmd != C_REF) err_now = 3'd1;
          ST_MRS: begin
            if (cmd != C_MRS)  err_now = 3'd1;
            else if (!mode_ok) err_now = 3'd2;
          end
          default:         err_now = 3'd1;
        endcase
      end else begin
        case (cmd)
          C_MRS:   if (any_open || !mode_ok) err_now = 3'd2;
          C_REF:   if (any_open) err_now = 3'd5;
          C_ACT:   if (sel_open) err_now = 3'd3;
          C_RD:    if (!sel_open) err_now = 3'd4;
          C_WR: begin
            if (!sel_open)      err_now = 3'd4;
            else if (rd_vld[0]) err_now = 3'd6;
          end
          default: err_now = 3'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_PWR;
      bank_open     <= '0;
      cl            <= 2'd3;
      init_done     <= 1'b0;
      cmd_error     <= 1'b0;
      err_code      <= 3'd0;
      refresh_count <= 16'd0;
      rd_vld        <= '0;
      rd_dat        <= '0;
    end else if (bus.clock_enable) begin
      rd_vld    <= {1'b0, rd_vld[2:1]};
      rd_dat[0] <= rd_dat[1];
      rd_dat[1] <= rd_dat[2];
      if (err_now != 3'd0) begin
        cmd_error <= 1'b1;
        err_code  <= err_now;
      end
      // Slot index is CL-1 so the word reaches the output slot CL-1 edges later.
      if (rd_ok) begin
        if (cl == 2'd2) begin
          rd_vld[1] <= 1'b1;
          rd_dat[1] <= mem[mem_idx];
        end else begin
          rd_vld[2] <= 1'b1;
          rd_dat[2] <= mem[mem_idx];
        end
      end
      if (accept) begin
        case (cmd)
          C_MRS: begin
            if (state == ST_MRS || (ready && !any_open)) begin
              cl <= mode_ok ? bus.addr[5:4] : 2'd3;
              if (state == ST_MRS) begin
                state     <= ST_READY;
                init_done <= 1'b1;
              end
            end
          end
          C_REF: begin
            if ((state == ST_REF1 || state == ST_REF2 || ready) && !any_open) begin
              if (refresh_count != 16'hFFFF) refresh_count <= refresh_count + 16'd1;
              if (state == ST_REF1)      state <= ST_REF2;
              else if (state == ST_REF2) state <= ST_MRS;
            end
          end
          C_PRE: begin
            if (state == ST_PWR && a10) state <= ST_REF1;
            else if (ready) begin
              if (a10) bank_open <= '0;
              else     bank_open[bus.bank_addr] <= 1'b0;
            end
          end
          C_ACT:       if (act_ok) bank_open[bus.bank_addr] <= 1'b1;
          C_RD, C_WR:  if (ready && sel_open && a10) bank_open[bus.bank_addr] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.clock_enable && act_ok) bank_row[bus.bank_addr] <= bus.addr[ROW_WIDTH-1:0];
    if (bus.clock_enable && wr_ok) begin
      if (!bus.data_mask_low)  mem[mem_idx][7:0]  <= data[7:0];
      if (!bus.data_mask_high) mem[mem_idx][15:8] <= data[15:8];
    end
  end
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder with a transaction-level reference model checked every cycle.
module tb_sdram_responder;
  localparam int RW = 11;
  localparam int CW = 9;
  localparam int BW = 2;
  localparam int MAW = 12;

  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done, cmd_error;
  logic [2:0]  err_code;
  logic [15:0] refresh_count;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_dq = 16'h0;
  wire  [15:0] data;

  int n_chk = 0;
  int n_err = 0;
  bit run_chk = 0;

  sdram_responder_if #(.ADDR_WIDTH(RW), .BANK_WIDTH(BW)) bus ();

  assign data = tb_oe ? tb_dq : 16'hzzzz;

  sdram_responder #(.ROW_WIDTH(RW), .COL_WIDTH(CW), .BANK_WIDTH(BW), .MEM_AW(MAW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .data(data),
    .init_done(init_done), .cmd_error(cmd_error), .err_code(err_code),
    .refresh_count(refresh_count)
  );

  always #5 clk = ~clk;

  // Reference model: stage 0..4 = power-up, ref1, ref2, mrs, ready
  typedef struct { int due; logic [15:0] val; logic [15:0] km; } rd_t;
  int          m_stage, m_cl, m_code, m_refs, m_cyc;
  bit          m_init, m_err;
  bit          m_open [4];
  int          m_row  [4];
  logic [15:0] m_mem [int];
  logic [15:0] m_km  [int];
  rd_t         m_rd [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_program(input int a, inout int code);
    int c;
    c = (a >> 4) & 7;
    if ((c == 2 || c == 3) && (a & 7) == 0) m_cl = c;
    else begin m_cl = 3; code = 2; end
  endtask

  task automatic model_step();
    int code, b, a, col, idx, cmd;
    bit a10, any_open, pend;
    rd_t e;
    if (!rst_n) begin
      m_stage = 0; m_cl = 3; m_code = 0; m_refs = 0; m_cyc = 0; m_init = 0; m_err = 0;
      for (int i = 0; i < 4; i++) m_open[i] = 0;
      m_rd.delete();
      return;
    end
    if (!bus.clock_enable) return;
    code = 0; b = int'(bus.bank_addr); a = int'(bus.addr); cmd = int'({bus.ras_n, bus.cas_n, bus.we_n});
    a10 = bus.addr[10]; col = a % 512;
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    pend = 0;
    foreach (m_rd[i]) if (m_rd[i].due == m_cyc) pend = 1;
    idx = (b * (1 << 20) + m_row[b] * 512 + col) % 4096;
    if (!bus.cs_n && cmd != 7 && cmd != 6) begin
      if (m_stage < 4) begin
        case (m_stage)
          0: if (cmd == 2 && a10) m_stage = 1; else code = 1;
          1, 2: if (cmd == 1) begin m_stage++; m_refs++; end else code = 1;
          default: if (cmd == 0) begin m_program(a, code); m_stage = 4; m_init = 1; end else code = 1;
        endcase
      end else begin
        case (cmd)
          0: if (any_open) code = 2; else m_program(a, code);
          1: if (any_open) code = 5; else if (m_refs < 65535) m_refs++;
          2: if (a10) for (int i = 0; i < 4; i++) m_open[i] = 0; else m_open[b] = 0;
          3: if (m_open[b]) code = 3; else begin m_open[b] = 1; m_row[b] = a; end
          5: if (!m_open[b]) code = 4;
             else begin
               e.due = m_cyc + m_cl;
               e.val = m_mem.exists(idx) ? m_mem[idx] : 16'h0;
               e.km  = m_km.exists(idx)  ? m_km[idx]  : 16'h0;
               m_rd.push_back(e);
               if (a10) m_open[b] = 0;
             end
          4: if (!m_open[b]) code = 4;
             else begin
               if (pend) code = 6;
               if (!m_mem.exists(idx)) begin m_mem[idx] = 16'h0; m_km[idx] = 16'h0; end
               if (!bus.data_mask_low)  begin m_mem[idx][7:0]  = tb_dq[7:0];  m_km[idx][7:0]  = 8'hFF; end
               if (!bus.data_mask_high) begin m_mem[idx][15:8] = tb_dq[15:8]; m_km[idx][15:8] = 8'hFF; end
               if (a10) m_open[b] = 0;
             end
          default: ;
        endcase
      end
    end
    if (code != 0) begin m_err = 1; m_code = code; end
    m_cyc++;
    for (int i = m_rd.size() - 1; i >= 0; i--) if (m_rd[i].due < m_cyc) m_rd.delete(i);
  endtask

  task automatic compare();
    logic eo;
    logic [15:0] ev, ek;
    bit wr_now;
    eo = 0; ev = 0; ek = 0;
    wr_now = bus.clock_enable && !bus.cs_n && ({bus.ras_n, bus.cas_n, bus.we_n} == C_WR);
    if (rst_n) foreach (m_rd[i]) if (m_rd[i].due == m_cyc) begin
      eo = !wr_now; ev = m_rd[i].val; ek = m_rd[i].km;
    end
    chk("m_init_done", init_done, m_init);
    chk("m_cmd_error", cmd_error, m_err);
    chk("m_err_code", err_code, m_code[2:0]);
    chk("m_refresh_count", refresh_count, m_refs[15:0]);
    chk("m_data_drive", dut.data_oe, eo);
    if (eo && ek != 16'h0) chk("m_rd_data", data & ek, ev & ek);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (run_chk) compare();
  end

  task automatic set_nop();
    bus.clock_enable = 1'b1; bus.cs_n = 1'b0;
    {bus.ras_n, bus.cas_n, bus.we_n} = C_NOP;
    bus.data_mask_low = 1'b0; bus.data_mask_high = 1'b0;
    tb_oe = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input int b = 0, input int a = 0,
                       input logic [15:0] wd = 16'h0, input logic [1:0] msk = 2'b00);
    #1;
    bus.clock_enable = 1'b1; bus.cs_n = 1'b0;
    {bus.ras_n, bus.cas_n, bus.we_n} = c;
    bus.bank_addr = BW'(b); bus.addr = RW'(a);
    {bus.data_mask_high, bus.data_mask_low} = msk;
    tb_dq = wd; tb_oe = (c == C_WR);
    @(posedge clk); #1;
    set_nop();
  endtask

  initial begin
    set_nop(); bus.addr = '0; bus.bank_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_cmd_error", cmd_error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_refresh", refresh_count, 0);
    chk("rst_drive", dut.data_oe, 0);
    run_chk = 1;
    rst_n = 1'b1;
    @(posedge clk);

    // init sequence
    issue(C_PRE, 0, 1 << 10);
    issue(C_REF);
    issue(C_REF);
    issue(C_MRS, 0, 'b1000110000);
    @(negedge clk);
    chk("init_done", init_done, 1);
    chk("init_cmd_error", cmd_error, 0);
    chk("init_refresh", refresh_count, 2);

    // write with auto-precharge, reopen, read at CL=3
    issue(C_ACT, 1, 5);
    issue(C_WR, 1, (1 << 10) | 3, 16'hA55A, 2'b00);
    issue(C_ACT, 1, 5);
    issue(C_RD, 1, 3);
    @(negedge clk); chk("cl3_k0_drive", dut.data_oe, 0);
    @(negedge clk); chk("cl3_k1_drive", dut.data_oe, 0);
    @(negedge clk); chk("cl3_k2_drive", dut.data_oe, 1); chk("cl3_k2_data", data, 16'hA55A);
    @(negedge clk); chk("cl3_k3_drive", dut.data_oe, 0);

    // masked write then immediate read
    issue(C_WR, 1, 7, 16'hFFFF, 2'b00);
    issue(C_WR, 1, 7, 16'h1234, 2'b10);
    issue(C_RD, 1, 7, 16'h0, 2'b11);
    repeat (3) @(negedge clk);
    chk("mask_data", data, 16'hFF34);

    // back-to-back reads
    issue(C_RD, 1, 3);
    issue(C_RD, 1, 7);
    issue(C_RD, 1, 3);
    repeat (4) @(posedge clk);

    // write colliding with read output
    issue(C_RD, 1, 3);
    issue(C_NOP);
    issue(C_NOP);
    issue(C_WR, 1, 9, 16'h5A5A);
    @(negedge clk);
    chk("collide_code", err_code, 6);
    chk("collide_sticky", cmd_error, 1);
    issue(C_RD, 1, 9);
    repeat (4) @(posedge clk);

    // protocol errors
    issue(C_RD, 2, 0);
    @(negedge clk); chk("closed_rd_code", err_code, 4);
    issue(C_ACT, 1, 6);
    @(negedge clk); chk("dup_act_code", err_code, 3);
    issue(C_RD, 1, 3);
    repeat (4) @(posedge clk);
    issue(C_REF);
    @(negedge clk); chk("ref_open_code", err_code, 5); chk("ref_open_count", refresh_count, 2);
    issue(C_MRS, 0, 'h20);
    @(negedge clk); chk("mrs_open_code", err_code, 2);

    // reprogram to CL=2 with banks closed
    issue(C_PRE, 1, 0);
    issue(C_MRS, 0, 'h20);
    issue(C_ACT, 1, 5);
    issue(C_RD, 1, 3);
    @(negedge clk); chk("cl2_k0_drive", dut.data_oe, 0);
    @(negedge clk); chk("cl2_k1_drive", dut.data_oe, 1); chk("cl2_k1_data", data, 16'hA55A);

    // PRE all closes every bank; illegal CL falls back to 3
    issue(C_ACT, 2, 1);
    issue(C_PRE, 0, 1 << 10);
    issue(C_RD, 2, 0);
    issue(C_MRS, 0, 'h50);
    @(negedge clk); chk("bad_cl_code", err_code, 2);
    issue(C_ACT, 1, 5);
    issue(C_RD, 1, 7);
    repeat (4) @(posedge clk);

    // clock_enable low freezes a pending read
    issue(C_RD, 1, 3);
    #1 bus.clock_enable = 1'b0; {bus.ras_n, bus.cas_n, bus.we_n} = C_RD;
    repeat (3) @(posedge clk);
    #1 set_nop();
    repeat (4) @(posedge clk);

    // auto-precharge read, then access to the now-closed bank
    issue(C_RD, 1, (1 << 10) | 7);
    issue(C_RD, 1, 7);
    repeat (4) @(posedge clk);

    // reset in the middle of a read burst
    issue(C_ACT, 1, 5);
    issue(C_RD, 1, 3);
    repeat (3) @(negedge clk);
    chk("pre_rst_drive", dut.data_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_drive", dut.data_oe, 0);
    chk("mid_rst_init", init_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    issue(C_RD, 1, 3);
    @(negedge clk); chk("pre_init_rd_code", err_code, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
